// File: rtl/hm2reg_irq_timer_if.sv
// Bus between the Avalon-to-HostMot2 bridge and the interrupt timer.
// The bridge drives the registered strobes; the timer returns read data and int_n.
interface hm2reg_irq_timer_if #(
  parameter int ADDRESS_WIDTH = 14,
  parameter int DATA_WIDTH    = 32
);
  logic [ADDRESS_WIDTH-1:0] bus_adr;
  logic [DATA_WIDTH-1:0]    bus_wdata;
  logic                     bus_write;
  logic                     bus_read;
  logic                     bus_chip_sel;
  logic [DATA_WIDTH-1:0]    rd_data;
  logic                     int_n;

  modport master (
    output bus_adr, bus_wdata, bus_write, bus_read, bus_chip_sel,
    input  rd_data, int_n
  );

  modport slave (
    input  bus_adr, bus_wdata, bus_write, bus_read, bus_chip_sel,
    output rd_data, int_n
  );
endinterface

// File: rtl/hm2reg_irq_timer.sv
// Register-mapped periodic servo-thread interrupt timer behind the HostMot2 bridge.
// Define HM2REG_TIMER_MISSED_CNT_EN to build the saturating missed-expiry counter (STATUS[15:8]).
module hm2reg_irq_timer #(
  parameter int                       ADDRESS_WIDTH = 14,
  parameter int                       DATA_WIDTH    = 32,
  parameter int                       CNT_WIDTH     = 24,
  parameter int unsigned              PRESCALE      = 50,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = 14'h0100,
  parameter logic [DATA_WIDTH-1:0]    ID_VALUE      = 32'h54494D31
) (
  input  logic                 clk,
  input  logic                 reset_n,
  hm2reg_irq_timer_if.slave    bus,
  output logic                 tick_out
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic                  r_en;
  logic                  r_irq_en;
  logic                  r_oneshot;
  logic [CNT_WIDTH-1:0]  r_reload;
  logic [CNT_WIDTH-1:0]  r_count;
  logic                  r_pending;
  logic [PS_W-1:0]       r_presc;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_int_n;
  logic                  r_tick_out;

  logic                  w_hit;
  logic [2:0]            w_off;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_wr_ctrl;
  logic                  w_wr_reload;
  logic                  w_clr;
  logic                  w_start;
  logic                  w_tick;
  logic                  w_expiry;
  logic [7:0]            w_missed;
  logic [DATA_WIDTH-1:0] w_rd_mux;
  logic                  w_unused;

  assign w_hit       = bus.bus_chip_sel &&
                       (bus.bus_adr[ADDRESS_WIDTH-1:3] == BASE_ADDR[ADDRESS_WIDTH-1:3]);
  assign w_off       = bus.bus_adr[2:0];
  assign w_wr        = bus.bus_write && w_hit;
  assign w_rd        = bus.bus_read && w_hit;
  assign w_wr_ctrl   = w_wr && (w_off == 3'd0);
  assign w_wr_reload = w_wr && (w_off == 3'd1);
  assign w_clr       = w_wr && (w_off == 3'd3) && bus.bus_wdata[0];
  assign w_start     = w_wr_ctrl && bus.bus_wdata[0] && !r_en;
  assign w_tick      = r_en && (r_presc == PS_LAST);
  assign w_expiry    = w_tick && (r_count == '0);
  assign w_unused    = ^bus.bus_wdata;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_en       <= 1'b0;
      r_irq_en   <= 1'b0;
      r_oneshot  <= 1'b0;
      r_reload   <= '0;
      r_count    <= '0;
      r_pending  <= 1'b0;
      r_presc    <= '0;
      r_rd_data  <= '0;
      r_int_n    <= 1'b1;
      r_tick_out <= 1'b0;
    end else begin
      if (w_start || !r_en || (r_presc == PS_LAST))
        r_presc <= '0;
      else
        r_presc <= r_presc + PS_W'(1);

      if (w_start)
        r_count <= r_reload;
      else if (w_tick)
        r_count <= w_expiry ? r_reload : (r_count - CNT_WIDTH'(1));

      // A CTRL write in the expiry cycle overrides the one-shot self-disable.
      if (w_wr_ctrl) begin
        r_en      <= bus.bus_wdata[0];
        r_irq_en  <= bus.bus_wdata[1];
        r_oneshot <= bus.bus_wdata[2];
      end else if (w_expiry && r_oneshot) begin
        r_en <= 1'b0;
      end

      if (w_wr_reload)
        r_reload <= bus.bus_wdata[CNT_WIDTH-1:0];

      if (w_expiry)
        r_pending <= 1'b1;
      else if (w_clr)
        r_pending <= 1'b0;

      r_tick_out <= w_expiry;
      r_int_n    <= !(r_pending && r_irq_en);
      r_rd_data  <= w_rd ? w_rd_mux : '0;
    end
  end

`ifdef HM2REG_TIMER_MISSED_CNT_EN
  logic [7:0] r_missed;

  always_ff @(posedge clk) begin
    if (!reset_n)
      r_missed <= '0;
    else if (w_clr)
      r_missed <= '0;
    else if (w_expiry && r_pending && (r_missed != 8'hFF))
      r_missed <= r_missed + 8'd1;
  end

  assign w_missed = r_missed;
`else
  assign w_missed = '0;
`endif

  always_comb begin
    w_rd_mux = '0;
    case (w_off)
      3'd0:    w_rd_mux[2:0]           = {r_oneshot, r_irq_en, r_en};
      3'd1:    w_rd_mux[CNT_WIDTH-1:0] = r_reload;
      3'd2:    w_rd_mux[CNT_WIDTH-1:0] = r_count;
      3'd3:    w_rd_mux[15:0]          = {w_missed, 7'b0, r_pending};
      3'd4:    w_rd_mux                = ID_VALUE;
      default: w_rd_mux                = '0;
    endcase
  end

  assign bus.rd_data = r_rd_data;
  assign bus.int_n   = r_int_n;
  assign tick_out    = r_tick_out;

endmodule
